// File: rtl/dp_jtag_master_pkg.sv
// Shared types for the JTAG TAP sequencer: command encoding, sequencer states
// and the legality rule applied to incoming commands.
package dp_jtag_master_pkg;

    localparam int JM_MAX_LEN = 64;

    typedef enum logic [1:0] {
        JM_RESET = 2'd0,
        JM_IR    = 2'd1,
        JM_DR    = 2'd2
    } jm_cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        TLR2RTI,
        SDS,
        SIS,
        CAP,
        SHIFT,
        E1UPD,
        RTI,
        DONE,
        RST5
    } jm_state_t;

    // Type 3 is reserved; the length only matters for scans.
    function automatic logic jm_cmd_legal(input logic [1:0] cmd_type, input logic [6:0] cmd_len);
        logic ok;
        ok = 1'b1;
        if (cmd_type == 2'd3) begin
            ok = 1'b0;
        end else if (cmd_type != JM_RESET) begin
            ok = (cmd_len != 7'd0) && (cmd_len <= 7'(JM_MAX_LEN));
        end
        return ok;
    endfunction

endpackage

// File: rtl/dp_jtag_master_tck_gen.sv
// Test-clock divider: low phase then high phase, CLK_DIV clk each, held low while disabled.
// Strobes mark the clk edge at which tck is about to rise or fall.
module dp_jtag_master_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tck_reg;
    logic          last;

    assign last     = (cnt_reg == LAST);
    assign rise_stb = en && !tck_reg && last;
    assign fall_stb = en && tck_reg && last;
    assign tck      = tck_reg;

    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (last) begin
            cnt_reg <= '0;
            tck_reg <= !tck_reg;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/dp_jtag_master.sv
// Command-driven JTAG TAP sequencer: walks the TAP through IR/DR scans or a
// TAP reset, shifting up to 64 bits LSB-first and returning the captured tdo bits.
module dp_jtag_master
    import dp_jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [6:0]  cmd_len,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    output logic        trst,
    input  logic        tdo
);

    jm_state_t   state_reg, state_next;
    logic [6:0]  cnt_reg, cnt_next;
    logic [6:0]  len_reg;
    logic [63:0] data_reg;
    logic [63:0] cap_reg;
    logic        is_ir_reg;
    logic        err_reg;
    logic        in_tlr_reg;
    logic        tms_reg, tdi_reg, trst_reg;
    logic        ready_reg, rsp_valid_reg;
    logic        tms_next, tdi_next;
    logic        accept, legal, tck_en, fall_stb, rise_stb;

    assign accept = cmd_valid && ready_reg;
    assign legal  = jm_cmd_legal(cmd_type, cmd_len);
    assign tck_en = (state_reg != IDLE) && (state_reg != DONE);

    dp_jtag_master_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .resetn   (resetn),
        .en       (tck_en),
        .tck      (tck),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // Steps advance on the clk edge where tck falls, so each step owns one full tck period.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next = 7'd0;
                    if (!legal)
                        state_next = DONE;
                    else if (cmd_type == JM_RESET)
                        state_next = RST5;
                    else if (in_tlr_reg)
                        state_next = TLR2RTI;
                    else
                        state_next = SDS;
                end
            end
            DONE: state_next = IDLE;
            default: begin
                if (fall_stb) begin
                    unique case (state_reg)
                        TLR2RTI: state_next = SDS;
                        SDS:     state_next = is_ir_reg ? SIS : CAP;
                        SIS:     state_next = CAP;
                        // Two periods: enter Capture, then Capture -> Shift.
                        CAP: begin
                            if (cnt_reg == 7'd0) begin
                                cnt_next = 7'd1;
                            end else begin
                                cnt_next   = 7'd0;
                                state_next = SHIFT;
                            end
                        end
                        SHIFT: begin
                            if (cnt_reg == len_reg - 7'd1) begin
                                cnt_next   = 7'd0;
                                state_next = E1UPD;
                            end else begin
                                cnt_next = cnt_reg + 7'd1;
                            end
                        end
                        E1UPD: state_next = RTI;
                        RTI:   state_next = DONE;
                        RST5: begin
                            if (cnt_reg == 7'd4) begin
                                cnt_next   = 7'd0;
                                state_next = RTI;
                            end else begin
                                cnt_next = cnt_reg + 7'd1;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        tms_next = 1'b0;
        tdi_next = 1'b0;
        unique case (state_next)
            SDS, SIS, E1UPD, RST5: tms_next = 1'b1;
            SHIFT: begin
                tms_next = (cnt_next == len_reg - 7'd1);
                tdi_next = data_reg[cnt_next[5:0]];
            end
            default: tms_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            cnt_reg       <= 7'd0;
            len_reg       <= 7'd0;
            data_reg      <= 64'd0;
            cap_reg       <= 64'd0;
            is_ir_reg     <= 1'b0;
            err_reg       <= 1'b0;
            in_tlr_reg    <= 1'b1;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            trst_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            trst_reg      <= 1'b1;
            ready_reg     <= (state_next == IDLE);
            rsp_valid_reg <= (state_next == DONE);
            if (accept) begin
                len_reg   <= cmd_len;
                data_reg  <= cmd_data;
                is_ir_reg <= (cmd_type == JM_IR);
                err_reg   <= !legal;
                cap_reg   <= 64'd0;
            end
            // Outside a scan the pins keep their last level (RTI leaves tms at 0).
            if (state_next != IDLE && state_next != DONE) begin
                tms_reg <= tms_next;
                tdi_reg <= tdi_next;
            end
            if (rise_stb && state_reg == SHIFT)
                cap_reg[cnt_reg[5:0]] <= tdo;
            if (fall_stb && (state_reg == TLR2RTI || state_reg == RTI))
                in_tlr_reg <= 1'b0;
        end
    end

    assign cmd_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = cap_reg;
    assign rsp_err   = err_reg;
    assign tms       = tms_reg;
    assign tdi       = tdi_reg;
    assign trst      = trst_reg;

endmodule

// File: tb/tb_dp_jtag_master.sv
// Bench for dp_jtag_master: a tck-edge monitor plays a TAP target with random tdo
// and a command-level model predicts tms sequence, tdi bits and response.
module tb_dp_jtag_master;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [6:0]  cmd_len = 7'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        tdo = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, tck, tms, tdi, trst;
    logic [63:0] rsp_data;

    int checks = 0;
    int failures = 0;
    bit model_in_tlr = 1'b1;
    bit pattern [128];
    bit tms_q[$];
    bit tdi_q[$];

    always #5 clk = ~clk;

    dp_jtag_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .trst      (trst),
        .tdo       (tdo)
    );

    // Target side: record pins at each tck rise and present the next tdo bit.
    always @(posedge tck) begin
        tms_q.push_back(tms);
        tdi_q.push_back(tdi);
        if (tms_q.size() < 128) tdo = pattern[tms_q.size()];
        else tdo = 1'b0;
    end

    task automatic run_cmd(input logic [1:0] t, input logic [6:0] len, input logic [63:0] data,
                           input bit hold_valid, input string name);
        bit          exp_tms[$];
        bit          legal;
        int          pre, waited, tms_bad;
        logic [63:0] mask, exp_data, got_tdi, held;
        legal = (t != 2'd3) && (t == 2'd0 || (len >= 7'd1 && len <= 7'd64));
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 128; i++) pattern[i] = 1'($urandom_range(0, 1));
        tms_q.delete();
        tdi_q.delete();
        tdo = pattern[0];
        cmd_valid = 1'b1;
        cmd_type = t;
        cmd_len = len;
        cmd_data = data;
        @(posedge clk);
        #1;
        if (hold_valid) begin
            cmd_type = 2'($urandom_range(0, 3));
            cmd_len = 7'($urandom);
            cmd_data = {$urandom, $urandom};
        end else begin
            cmd_valid = 1'b0;
        end
        // Expected pin activity from the TAP state graph.
        pre = 0;
        if (legal && t == 2'd0) begin
            for (int i = 0; i < 5; i++) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end else if (legal) begin
            if (model_in_tlr) exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b1);
            if (t == 2'd1) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b0);
            pre = exp_tms.size();
            for (int k = 0; k < int'(len); k++) exp_tms.push_back(k == int'(len) - 1);
            exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
        end
        mask = (len >= 7'd64) ? '1 : ((64'd1 << len) - 64'd1);
        exp_data = 64'd0;
        if (legal && t != 2'd0)
            for (int k = 0; k < int'(len); k++) exp_data[k] = pattern[pre + k];
        waited = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s rsp_timeout: rsp_valid=%b required 1", name, rsp_valid);
        end
        if (!legal) begin
            checks++;
            if (waited != 0) begin
                failures++;
                $display("FAIL %s err_latency: waited=%0d required 0", name, waited);
            end
        end
        checks++;
        if (tms_q.size() != exp_tms.size()) begin
            failures++;
            $display("FAIL %s tck_rises: got=%0d required %0d", name, tms_q.size(), exp_tms.size());
        end
        tms_bad = 0;
        for (int i = 0; i < exp_tms.size() && i < tms_q.size(); i++)
            if (tms_q[i] != exp_tms[i]) tms_bad++;
        checks++;
        if (tms_bad != 0) begin
            failures++;
            $display("FAIL %s tms_seq: %0d wrong bits, required 0", name, tms_bad);
        end
        got_tdi = 64'd0;
        for (int k = 0; k < int'(len) && k < 64 && pre + k < tdi_q.size(); k++) got_tdi[k] = tdi_q[pre + k];
        if (legal && t != 2'd0) begin
            checks++;
            if (got_tdi !== (data & mask)) begin
                failures++;
                $display("FAIL %s tdi_bits: got=%h required %h", name, got_tdi, data & mask);
            end
        end
        checks++;
        if (rsp_err !== !legal) begin
            failures++;
            $display("FAIL %s rsp_err: got=%b required %b", name, rsp_err, !legal);
        end
        checks++;
        if (rsp_data !== exp_data) begin
            failures++;
            $display("FAIL %s rsp_data: got=%h required %h", name, rsp_data, exp_data);
        end
        held = rsp_data;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== held) begin
            failures++;
            $display("FAIL %s after_rsp: valid=%b ready=%b data=%h required 0 1 %h",
                     name, rsp_valid, cmd_ready, rsp_data, held);
        end
        if (legal) model_in_tlr = 1'b0;
        $display("txn %s type=%0d len=%0d data=%h rises=%0d rsp=%h err=%b",
                 name, t, len, data, tms_q.size(), rsp_data, rsp_err);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tck, tms, tdi, trst, cmd_ready, rsp_valid, rsp_err} !== 7'b0100000 || rsp_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_values: tck/tms/tdi/trst/rdy/vld/err=%b data=%h required 0100000 0",
                     {tck, tms, tdi, trst, cmd_ready, rsp_valid, rsp_err}, rsp_data);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({tck, tms, trst, cmd_ready, rsp_valid} !== 5'b01110) begin
            failures++;
            $display("FAIL reset_release: tck/tms/trst/rdy/vld=%b required 01110",
                     {tck, tms, trst, cmd_ready, rsp_valid});
        end
        model_in_tlr = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_first_scan();
        run_cmd(2'd1, 7'd5, 64'h1F, 1'b0, "ir_from_tlr");
        run_cmd(2'd2, 7'd32, 64'hDEADBEEF, 1'b0, "dr32");
    endtask

    task automatic test_tap_reset();
        run_cmd(2'd0, 7'd1, 64'd0, 1'b0, "tap_reset");
    endtask

    task automatic test_random_scans();
        for (int i = 0; i < 12; i++)
            run_cmd(2'($urandom_range(1, 2)), 7'($urandom_range(1, 64)), {$urandom, $urandom},
                    i[0], "rand_scan");
    endtask

    task automatic test_boundaries();
        run_cmd(2'd2, 7'd1, {$urandom, $urandom}, 1'b0, "dr_len1");
        run_cmd(2'd1, 7'd64, {$urandom, $urandom}, 1'b0, "ir_len64");
        run_cmd(2'd2, 7'd64, {$urandom, $urandom}, 1'b1, "dr_len64_busy_valid");
    endtask

    task automatic test_errors();
        run_cmd(2'd2, 7'd0, {$urandom, $urandom}, 1'b0, "err_len0");
        run_cmd(2'd1, 7'($urandom_range(65, 127)), {$urandom, $urandom}, 1'b0, "err_len_big");
        run_cmd(2'd3, 7'd8, {$urandom, $urandom}, 1'b0, "err_type3");
        run_cmd(2'd2, 7'd16, {$urandom, $urandom}, 1'b0, "dr_after_err");
    endtask

    task automatic test_abort();
        int waited;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tms_q.delete();
        tdi_q.delete();
        cmd_valid = 1'b1;
        cmd_type = 2'd2;
        cmd_len = 7'd40;
        cmd_data = {$urandom, $urandom};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        waited = 0;
        // DR with in_tlr clear: 3 lead-in rises, then bit 10 follows 10 shift rises.
        while (!(tms_q.size() == 13 && tck == 1'b0) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tms_q.size() != 13) begin
            failures++;
            $display("FAIL abort_reach_bit10: rises=%0d required 13", tms_q.size());
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({tck, tms, trst, cmd_ready, rsp_valid} !== 5'b01000 || rsp_data !== 64'd0) begin
            failures++;
            $display("FAIL abort_reset: tck/tms/trst/rdy/vld=%b data=%h required 01000 0",
                     {tck, tms, trst, cmd_ready, rsp_valid}, rsp_data);
        end
        $display("txn abort at shift bit 10 of len40 dr");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        model_in_tlr = 1'b1;
        run_cmd(2'd1, 7'($urandom_range(1, 64)), {$urandom, $urandom}, 1'b0, "ir_after_abort");
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_tap_reset();
        test_random_scans();
        test_boundaries();
        test_errors();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
